// File: rtl/display_mux.sv
// Multi-source seven-segment display path: field-to-digit conversion, edit blink and source-change banner.
// Optional build macro LEADING_ZERO_BLANK_EN blanks the leading zero of the most significant field.
module display_mux #(
    parameter int NSRC       = 4,
    parameter int NFIELD     = 4,
    parameter int BLINK_HALF = 6000000,
    parameter int BANNER_CYC = 12000000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NSRC*NFIELD*7-1:0]    src_vals,
    input  logic [$clog2(NSRC)-1:0]     sel,
    input  logic                        edit_en,
    input  logic [$clog2(NFIELD)-1:0]   edit_field,
    input  logic [2*NFIELD-1:0]         dp_mask,
    output logic [2*NFIELD*8-1:0]       ss7,
    output logic                        banner_active
);

    localparam int SELW = $clog2(NSRC);
    localparam int NDIG = 2 * NFIELD;
    localparam int BLW  = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int BNW  = (BANNER_CYC > 1) ? $clog2(BANNER_CYC) : 1;

    localparam logic [6:0]     SEG_DASH    = 7'h40;
    localparam logic [BLW-1:0] BLINK_LAST  = BLW'(BLINK_HALF - 1);
    localparam logic [BNW-1:0] BANNER_LOAD = BNW'(BANNER_CYC - 1);

    typedef enum logic {
        SHOW,
        BANNER
    } state_t;

    state_t          state;
    logic [SELW-1:0] sel_q;
    logic [SELW-1:0] sel_eff;
    logic            armed;
    logic            sel_changed;
    logic            show_banner;
    logic            blank_field;
    logic [BNW-1:0]  banner_cnt;
    logic [BLW-1:0]  blink_cnt;
    logic            blink_on;
    logic [NDIG*8-1:0] ss7_next;

    function automatic logic [6:0] hex2seg7(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Returns {tens segments, ones segments}; anything above 99 shows two dashes.
    function automatic logic [13:0] field_segs(input logic [6:0] v);
        logic [3:0] tens_d;
        logic [3:0] ones_d;
        tens_d = 4'(v / 7'd10);
        ones_d = 4'(v % 7'd10);
        if (v > 7'd99) begin
            return {SEG_DASH, SEG_DASH};
        end
        return {hex2seg7(tens_d), hex2seg7(ones_d)};
    endfunction

    assign sel_eff     = (int'(sel) < NSRC) ? sel : '0;
    assign sel_changed = armed && (sel_eff != sel_q);
    assign show_banner = sel_changed || ((state == BANNER) && (banner_cnt != '0));
    assign blank_field = edit_en && !blink_on && (int'(edit_field) < NFIELD);

    // armed stays low for the first cycle after reset so the initial sel never raises a banner.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= SHOW;
            sel_q         <= '0;
            armed         <= 1'b0;
            banner_cnt    <= '0;
            banner_active <= 1'b0;
        end else begin
            armed <= 1'b1;
            sel_q <= sel_eff;
            case (state)
                SHOW: begin
                    if (sel_changed) begin
                        state         <= BANNER;
                        banner_cnt    <= BANNER_LOAD;
                        banner_active <= 1'b1;
                    end
                end
                BANNER: begin
                    if (sel_changed) begin
                        banner_cnt <= BANNER_LOAD;
                    end else if (banner_cnt == '0) begin
                        state         <= SHOW;
                        banner_active <= 1'b0;
                    end else begin
                        banner_cnt <= banner_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_on  <= !blink_on;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // The next display is built from the post-edge FSM view so the banner appears together with banner_active.
    always_comb begin
        logic [6:0]  v;
        logic [13:0] segs;
        logic [7:0]  tens;
        logic [7:0]  ones;
        ss7_next = '0;
        v        = '0;
        segs     = '0;
        tens     = '0;
        ones     = '0;
        if (show_banner) begin
            ss7_next[(NDIG-1)*8 +: 8] = {1'b0, SEG_DASH};
            ss7_next[(NDIG-2)*8 +: 8] = {1'b0, hex2seg7(4'(sel_eff))};
        end else begin
            for (int f = 0; f < NFIELD; f++) begin
                v    = src_vals[(int'(sel_eff) * NFIELD + f) * 7 +: 7];
                segs = field_segs(v);
                tens = {dp_mask[2*f+1], segs[13:7]};
                ones = {dp_mask[2*f], segs[6:0]};
`ifdef LEADING_ZERO_BLANK_EN
                if ((f == NFIELD - 1) && (v < 7'd10)) begin
                    tens = {dp_mask[2*f+1], 7'h00};
                end
`endif
                if (blank_field && (int'(edit_field) == f)) begin
                    tens = 8'h00;
                    ones = 8'h00;
                end
                ss7_next[(2*f+1)*8 +: 8] = tens;
                ss7_next[(2*f)*8 +: 8]   = ones;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ss7 <= '0;
        end else begin
            ss7 <= ss7_next;
        end
    end

endmodule

// File: tb/tb_display_mux.sv
// Self-checking bench for display_mux: vector table for single-cycle behaviour plus banner, reset and blink sequences.
// Expectations are scoreboarded: pushed when stimulus is applied, popped after the next clock edge.
module tb_display_mux;

    localparam int NSRC       = 5;
    localparam int NFIELD     = 4;
    localparam int BLINK_HALF = 4;
    localparam int BANNER_CYC = 8;

    logic                      clk = 1'b0;
    logic                      rst = 1'b0;
    logic [NSRC*NFIELD*7-1:0]  src_vals;
    logic [2:0]                sel;
    logic                      edit_en;
    logic [1:0]                edit_field;
    logic [7:0]                dp_mask;
    logic [63:0]               ss7;
    logic                      banner_active;

    logic [41:0]               src_vals_b;
    logic                      sel_b;
    logic                      edit_en_b;
    logic [1:0]                edit_field_b;
    logic [5:0]                dp_mask_b;
    logic [47:0]               ss7_b;
    logic                      banner_active_b;

    typedef struct {
        string       name;
        logic [63:0] ss7;
        logic        ba;
    } exp_t;

    typedef struct {
        string       name;
        logic [6:0]  f3, f2, f1, f0;
        logic [2:0]  sel;
        logic [7:0]  dp;
        logic [63:0] ss7;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    localparam logic [63:0] BLINK_VAL   = 64'h065B_CFE6_6D7D_3F07;
    localparam logic [63:0] BLINK_BLANK = 64'h065B_0000_6D7D_3F07;
    localparam logic [63:0] SRC2_PLAIN  = 64'h5B06_664F_7D6D_7F07;
    localparam logic [47:0] B_STEADY    = 48'h065B_4F66_6D7D;

    always #5 clk = ~clk;

    display_mux #(
        .NSRC(NSRC), .NFIELD(NFIELD), .BLINK_HALF(BLINK_HALF), .BANNER_CYC(BANNER_CYC)
    ) dut (
        .clk(clk), .rst(rst), .src_vals(src_vals), .sel(sel), .edit_en(edit_en),
        .edit_field(edit_field), .dp_mask(dp_mask), .ss7(ss7), .banner_active(banner_active)
    );

    // Three fields make edit_field == NFIELD representable, exercising the invalid-field case.
    display_mux #(
        .NSRC(2), .NFIELD(3), .BLINK_HALF(BLINK_HALF), .BANNER_CYC(BANNER_CYC)
    ) dut_b (
        .clk(clk), .rst(rst), .src_vals(src_vals_b), .sel(sel_b), .edit_en(edit_en_b),
        .edit_field(edit_field_b), .dp_mask(dp_mask_b), .ss7(ss7_b), .banner_active(banner_active_b)
    );

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    task automatic check_output();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL scoreboard_empty: got 0 entries required 1");
        end else begin
            e = exp_q.pop_front();
            check_val({e.name, "_ss7"}, ss7, e.ss7);
            check_val({e.name, "_banner"}, 64'(banner_active), 64'(e.ba));
        end
    endtask

    task automatic apply_stimulus(input string name, input logic [63:0] e_ss7, input logic e_ba);
        exp_t e;
        e.name = name;
        e.ss7  = e_ss7;
        e.ba   = e_ba;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        check_output();
    endtask

    task automatic add_vec(input string name, input int f3, input int f2, input int f1, input int f0,
                           input int s, input logic [7:0] dp, input logic [63:0] e);
        vec_t v;
        v.name = name;
        v.f3 = 7'(f3); v.f2 = 7'(f2); v.f1 = 7'(f1); v.f0 = 7'(f0);
        v.sel = 3'(s);
        v.dp = dp;
        v.ss7 = e;
        vecs.push_back(v);
    endtask

    task automatic drive_src0(input int f3, input int f2, input int f1, input int f0);
        src_vals[27:0] = {7'(f3), 7'(f2), 7'(f1), 7'(f0)};
    endtask

    initial begin
        #20000;
        $display("[TB] FAIL watchdog: got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] prev;

        add_vec("first_update",  12, 34, 56, 7,   0, 8'h00, 64'h065B_4F66_6D7D_3F07);
        add_vec("over_100",      12, 34, 100, 7,  0, 8'h00, 64'h065B_4F66_4040_3F07);
        add_vec("over_127",      12, 34, 127, 7,  0, 8'h00, 64'h065B_4F66_4040_3F07);
        add_vec("back_99",       12, 34, 99, 7,   0, 8'h00, 64'h065B_4F66_6F6F_3F07);
        add_vec("dp_odd",        12, 34, 99, 7,   0, 8'hAA, 64'h865B_CF66_EF6F_BF07);
        add_vec("sel_invalid",   12, 34, 56, 7,   5, 8'h00, 64'h065B_4F66_6D7D_3F07);
`ifdef LEADING_ZERO_BLANK_EN
        add_vec("all_zero",      0, 0, 0, 0,      0, 8'h00, 64'h003F_3F3F_3F3F_3F3F);
        add_vec("lead_5",        5, 0, 1, 2,      0, 8'h00, 64'h006D_3F3F_3F06_3F5B);
`else
        add_vec("all_zero",      0, 0, 0, 0,      0, 8'h00, 64'h3F3F_3F3F_3F3F_3F3F);
        add_vec("lead_5",        5, 0, 1, 2,      0, 8'h00, 64'h3F6D_3F3F_3F06_3F5B);
`endif
        add_vec("lead_10",       10, 20, 30, 40,  0, 8'h00, 64'h063F_5B3F_4F3F_663F);
        add_vec("mixed",         99, 98, 0, 1,    0, 8'h00, 64'h6F6F_6F7F_3F3F_3F06);
        add_vec("dash_dp",       100, 127, 100, 101, 0, 8'hFF, 64'hC0C0_C0C0_C0C0_C0C0);
`ifdef LEADING_ZERO_BLANK_EN
        add_vec("lead_5_dp",     5, 34, 56, 7,    0, 8'h80, 64'h806D_4F66_6D7D_3F07);
`else
        add_vec("lead_5_dp",     5, 34, 56, 7,    0, 8'h80, 64'hBF6D_4F66_6D7D_3F07);
`endif

        src_vals = '0;
        src_vals[1*28 +: 28] = {7'd11, 7'd22, 7'd33, 7'd44};
        src_vals[2*28 +: 28] = {7'd21, 7'd43, 7'd65, 7'd87};
        src_vals[3*28 +: 28] = {7'd33, 7'd44, 7'd55, 7'd66};
        src_vals[4*28 +: 28] = {7'd40, 7'd50, 7'd60, 7'd70};
        drive_src0(12, 34, 56, 7);
        sel = 3'd0;
        edit_en = 1'b0;
        edit_field = 2'd0;
        dp_mask = 8'h00;
        src_vals_b = {7'd1, 7'd2, 7'd3, 7'd12, 7'd34, 7'd56};
        sel_b = 1'b0;
        edit_en_b = 1'b1;
        edit_field_b = 2'd3;
        dp_mask_b = 6'h00;

        #2;
        check_val("reset_ss7", ss7, 64'h0);
        check_val("reset_banner", 64'(banner_active), 64'h0);
        @(posedge clk);
        #1;
        check_val("reset_clocked_ss7", ss7, 64'h0);
        rst = 1'b1;

        prev = 64'h0;
        foreach (vecs[i]) begin
            drive_src0(int'(vecs[i].f3), int'(vecs[i].f2), int'(vecs[i].f1), int'(vecs[i].f0));
            sel = vecs[i].sel;
            dp_mask = vecs[i].dp;
            #1;
            check_val({vecs[i].name, "_hold"}, ss7, prev);
            apply_stimulus(vecs[i].name, vecs[i].ss7, 1'b0);
            prev = vecs[i].ss7;
        end

        // Banner after 0 -> 2 with odd decimal points requested; dp must be suppressed while the banner shows.
        drive_src0(12, 34, 56, 7);
        dp_mask = 8'hAA;
        sel = 3'd2;
        for (int k = 0; k < BANNER_CYC; k++) apply_stimulus("banner2", 64'h405B_0000_0000_0000, 1'b1);
        apply_stimulus("after_banner2", 64'hDB06_E64F_FD6D_FF07, 1'b0);
        apply_stimulus("after_banner2_hold", 64'hDB06_E64F_FD6D_FF07, 1'b0);

        // Retrigger: change to 1, then to 3 four cycles later; banner lasts 4 + BANNER_CYC cycles.
        dp_mask = 8'h00;
        sel = 3'd1;
        for (int k = 0; k < 4; k++) apply_stimulus("banner1", 64'h4006_0000_0000_0000, 1'b1);
        sel = 3'd3;
        for (int k = 0; k < BANNER_CYC; k++) apply_stimulus("banner3", 64'h404F_0000_0000_0000, 1'b1);
        apply_stimulus("after_banner3", 64'h4F4F_6666_6D6D_7D7D, 1'b0);

        // Reset in the middle of a banner; the source selected at release shows without a banner.
        sel = 3'd4;
        apply_stimulus("banner4", 64'h4066_0000_0000_0000, 1'b1);
        apply_stimulus("banner4", 64'h4066_0000_0000_0000, 1'b1);
        rst = 1'b0;
        sel = 3'd2;
        #1;
        check_val("midreset_ss7", ss7, 64'h0);
        check_val("midreset_banner", 64'(banner_active), 64'h0);
        @(posedge clk);
        #1;
        check_val("midreset_clocked_ss7", ss7, 64'h0);
        rst = 1'b1;
        apply_stimulus("release_src2", SRC2_PLAIN, 1'b0);
        apply_stimulus("release_src2_hold", SRC2_PLAIN, 1'b0);

        // Blink from a known phase: fresh reset, field 2 blinks with its decimal points enabled.
        rst = 1'b0;
        sel = 3'd0;
        drive_src0(12, 34, 56, 7);
        dp_mask = 8'h30;
        edit_en = 1'b1;
        edit_field = 2'd2;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int n = 1; n <= 4 * BLINK_HALF; n++) begin
            apply_stimulus("blink", (((n - 1) / BLINK_HALF) % 2 == 0) ? BLINK_VAL : BLINK_BLANK, 1'b0);
            check_val("blink_invalid_field", 64'(ss7_b), 64'(B_STEADY));
        end
        edit_en = 1'b0;
        for (int n = 0; n < 2 * BLINK_HALF; n++) begin
            apply_stimulus("edit_off", BLINK_VAL, 1'b0);
        end
        check_val("invalid_field_banner", 64'(banner_active_b), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
